// File: rtl/prep6_acc_pkg.sv
// Shared types and constants for the arbitrated accumulator.
package prep6_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 16;
    localparam int LENW_DEF  = 8;
    localparam int IDW_DEF   = $clog2(NREQ_DEF);

    function automatic int idw_of(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/prep6_acc_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after the pointer, wrapping.
module prep6_rr_pick
    import prep6_acc_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [IDW-1:0]  o_win,
    output logic            o_any
);

    // Scan farthest-first so the nearest set bit to the pointer wins.
    always_comb begin
        o_win = '0;
        o_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_win = IDW'((int'(i_ptr) + k) % NREQ);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prep6_acc_arbiter.sv
// Round-robin arbiter sharing one accumulate datapath; grant is locked for a whole burst
// and the sum is held until the consumer acknowledges it.
module prep6_acc_arbiter
    import prep6_acc_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int LENW  = LENW_DEF,
    localparam int IDW   = idw_of(NREQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*LENW-1:0]  i_len,
    input  logic [NREQ*WIDTH-1:0] i_d,
    input  logic [NREQ-1:0]       i_dvalid,
    output logic [NREQ-1:0]       o_dready,
    output logic [NREQ-1:0]       o_gnt,
    output logic [WIDTH-1:0]      o_q,
    output logic                  o_qvalid,
    output logic [IDW-1:0]        o_qid,
    output logic                  o_ovf,
    input  logic                  i_qack,
    output logic                  o_busy
);

    state_e            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [WIDTH-1:0]  r_q;
    logic              r_qvalid;
    logic              r_ovf;
    logic [IDW-1:0]    r_qid;
    logic [IDW-1:0]    r_ptr;
    logic [LENW-1:0]   r_cnt;

    logic [IDW-1:0]    w_win;
    logic              w_any;
    logic [LENW-1:0]   w_win_len;
    logic [WIDTH-1:0]  w_gd;
    logic              w_gvalid;
    logic [WIDTH:0]    w_sum;

    prep6_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    // Select the winner's length and the granted requester's data lane.
    always_comb begin
        w_win_len = i_len[int'(w_win)*LENW +: LENW];
        w_gd      = i_d[int'(r_qid)*WIDTH +: WIDTH];
        w_gvalid  = i_dvalid[r_qid];
        w_sum     = {1'b0, r_q} + {1'b0, w_gd};
    end

    // Burst sequencer: grant, accumulate, hold result until acknowledged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_q      <= '0;
            r_qvalid <= 1'b0;
            r_ovf    <= 1'b0;
            r_qid    <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_qid <= w_win;
                        r_cnt <= w_win_len;
                        r_q   <= '0;
                        r_ovf <= 1'b0;
                        // A zero-length burst still shows its grant so the requester can drop REQ.
                        if (w_win_len == LENW'(0)) begin
                            r_state  <= DONE;
                            r_qvalid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_gvalid) begin
                        r_q   <= w_sum[WIDTH-1:0];
                        r_ovf <= r_ovf | w_sum[WIDTH];
                        r_cnt <= r_cnt - LENW'(1);
                        if (r_cnt == LENW'(1)) begin
                            r_state  <= DONE;
                            r_qvalid <= 1'b1;
                            r_gnt    <= '0;
                        end
                    end
                end
                DONE: begin
                    if (i_qack) begin
                        r_state  <= IDLE;
                        r_qvalid <= 1'b0;
                        r_gnt    <= '0;
                        r_ptr    <= (r_qid == IDW'(NREQ - 1)) ? '0 : r_qid + IDW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_dready = (r_state == ACCUM) ? r_gnt : '0;
    assign o_gnt    = r_gnt;
    assign o_q      = r_q;
    assign o_qvalid = r_qvalid;
    assign o_qid    = r_qid;
    assign o_ovf    = r_ovf;
    assign o_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_prep6_acc_arbiter.sv
// Directed bench for prep6_acc_arbiter with a transaction-level reference model.
module tb_prep6_acc_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int L  = 8;
    localparam int IW = 2;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic [N-1:0]     req    = '0;
    logic [N-1:0]     dvalid = '0;
    logic [N*L-1:0]   len    = '0;
    logic [N*W-1:0]   d      = '0;
    logic             qack   = 1'b0;
    logic [N-1:0]     dready;
    logic [N-1:0]     gnt;
    logic [W-1:0]     q;
    logic             qvalid;
    logic             ovf;
    logic             busy;
    logic [IW-1:0]    qid;

    int n_cmp = 0;
    int n_bad = 0;

    prep6_acc_arbiter #(.NREQ(N), .WIDTH(W), .LENW(L)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_len    (len),
        .i_d      (d),
        .i_dvalid (dvalid),
        .o_dready (dready),
        .o_gnt    (gnt),
        .o_q      (q),
        .o_qvalid (qvalid),
        .o_qid    (qid),
        .o_ovf    (ovf),
        .i_qack   (qack),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lenof(input int i);
        return int'(len[i*L +: L]);
    endfunction

    function automatic int dof(input int i);
        return int'(d[i*W +: W]);
    endfunction

    function automatic int rr_winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Reference model: one burst at a time, sum kept as a plain integer.
    int           m_sum = 0;
    int           m_rem = 0;
    int           m_ptr = 0;
    int           m_qid = 0;
    bit           m_acc = 1'b0;
    bit           m_val = 1'b0;
    bit           m_ovf = 1'b0;
    logic [N-1:0] m_gnt = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sum <= 0; m_rem <= 0; m_ptr <= 0; m_qid <= 0;
            m_acc <= 1'b0; m_val <= 1'b0; m_ovf <= 1'b0; m_gnt <= '0;
        end else if (m_acc) begin
            if (dvalid[m_qid]) begin
                m_sum <= (m_sum + dof(m_qid)) % 65536;
                if (m_sum + dof(m_qid) > 65535) m_ovf <= 1'b1;
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_acc <= 1'b0;
                    m_val <= 1'b1;
                    m_gnt <= '0;
                end
            end
        end else if (m_val) begin
            if (qack) begin
                m_val <= 1'b0;
                m_gnt <= '0;
                m_ptr <= (m_qid + 1) % N;
            end
        end else if (rr_winner(req, m_ptr) >= 0) begin
            m_qid <= rr_winner(req, m_ptr);
            m_sum <= 0;
            m_ovf <= 1'b0;
            m_rem <= lenof(rr_winner(req, m_ptr));
            m_gnt <= 4'b0001 << rr_winner(req, m_ptr);
            if (lenof(rr_winner(req, m_ptr)) == 0) m_val <= 1'b1;
            else m_acc <= 1'b1;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        check("gnt",    32'(gnt),    32'(m_gnt));
        check("dready", 32'(dready), m_acc ? 32'(m_gnt) : 32'd0);
        check("q",      32'(q),      m_sum);
        check("qvalid", 32'(qvalid), 32'(m_val));
        check("qid",    32'(qid),    m_qid);
        check("ovf",    32'(ovf),    32'(m_ovf));
        check("busy",   32'(busy),   32'(m_acc | m_val));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len[i*L +: L] = L'(v);
    endtask

    task automatic set_d(input int i, input int v);
        d[i*W +: W] = W'(v);
    endtask

    task automatic wait_qvalid();
        int cnt = 0;
        while (qvalid !== 1'b1 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check("qvalid_wait", 32'(qvalid), 32'd1);
    endtask

    int exp_id[5] = '{0, 1, 2, 3, 0};
    int exp_q[5]  = '{1, 2, 3, 4, 1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then single 3-beat burst from requester 0.
        step(); step();
        rst = 1'b0;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req = 4'b0001; set_len(0, 3);
        step();
        check("t1_gnt", 32'(gnt), 32'h1);
        req = 4'b0000; dvalid = 4'b0001; set_d(0, 1);
        step(); set_d(0, 2);
        step(); set_d(0, 3);
        step(); dvalid = 4'b0000;
        check("t1_q", 32'(q), 32'h6);
        check("t1_qvalid", 32'(qvalid), 32'd1);
        check("t1_model_q", m_sum, 32'h6);
        step(); step();
        check("t1_q_hold", 32'(q), 32'h6);
        qack = 1'b1; step(); qack = 1'b0;

        // Round-robin with all four requesting, single-word bursts.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            set_len(i, 1);
            set_d(i, i + 1);
        end
        dvalid = 4'b1111; qack = 1'b1;
        for (int b = 0; b < 5; b++) begin
            wait_qvalid();
            check("rr_qid", 32'(qid), exp_id[b]);
            check("rr_q", 32'(q), exp_q[b]);
            if (b < 4) @(negedge clk);
        end
        req = 4'b0000; dvalid = 4'b0000;
        step(); qack = 1'b0;

        // Wrap-around sets OVF; requester 1 is next in line.
        step();
        req = 4'b0010; set_len(1, 2);
        step();
        check("t3_gnt", 32'(gnt), 32'h2);
        req = 4'b0000; dvalid = 4'b0010; set_d(1, 16'hFFFF);
        step(); set_d(1, 2);
        step(); dvalid = 4'b0000;
        check("t3_q", 32'(q), 32'h1);
        check("t3_ovf", 32'(ovf), 32'd1);
        check("t3_model_ovf", 32'(m_ovf), 32'd1);
        qack = 1'b1; step(); qack = 1'b0;

        // Stall and isolation: requester 2 granted, requester 1 drives data.
        req = 4'b0100; set_len(2, 2);
        step();
        check("t4_gnt", 32'(gnt), 32'h4);
        check("t4_ovf_clear", 32'(ovf), 32'd0);
        req = 4'b0000;
        set_d(1, 16'h1234);
        for (int c = 0; c < 4; c++) begin
            dvalid = (c == 0 || c == 3) ? 4'b0110 : 4'b0010;
            set_d(2, (c == 0) ? 16'h0010 : (c == 3) ? 16'h0020 : 16'hDEAD);
            step();
            check("t4_dready1", 32'(dready[1]), 32'd0);
        end
        dvalid = 4'b0000;
        check("t4_q", 32'(q), 32'h30);
        check("t4_qid", 32'(qid), 32'd2);
        qack = 1'b1; step(); qack = 1'b0;

        // Zero-length burst and delayed acknowledge.
        req = 4'b1000; set_len(3, 0);
        step();
        check("t5_qvalid", 32'(qvalid), 32'd1);
        check("t5_q", 32'(q), 32'd0);
        check("t5_qid", 32'(qid), 32'd3);
        req = 4'b0001; set_len(0, 4);
        for (int c = 0; c < 5; c++) begin
            step();
            check("t5_hold_qvalid", 32'(qvalid), 32'd1);
            check("t5_no_new_gnt", 32'(gnt), 32'h8);
        end
        qack = 1'b1; step(); qack = 1'b0;
        check("t5_idle_gnt", 32'(gnt), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        step();
        check("t6_gnt", 32'(gnt), 32'h1);

        // Mid-burst reset after two of four beats.
        req = 4'b0000; dvalid = 4'b0001; set_d(0, 8);
        step(); step();
        dvalid = 4'b0000;
        check("t6_partial", 32'(q), 32'h10);
        rst = 1'b1;
        #1;
        check("t6_rst_q", 32'(q), 32'd0);
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_dready", 32'(dready), 32'd0);
        check("t6_rst_qvalid", 32'(qvalid), 32'd0);
        #1 rst = 1'b0;
        step();
        req = 4'b0001; set_len(0, 1); set_d(0, 7);
        step();
        check("t6_regnt", 32'(gnt), 32'h1);
        check("t6_fresh_q", 32'(q), 32'd0);
        req = 4'b0000; dvalid = 4'b0001;
        step(); dvalid = 4'b0000;
        check("t6_q", 32'(q), 32'h7);
        qack = 1'b1; step(); qack = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prep6_acc_arbiter.md
Name: prep6_acc_arbiter

Overview:
- Shares one 16-bit accumulate datapath (Q <= Q + D) between NREQ requesters.
- Each requester asks for a burst of LEN words. The block grants requesters round-robin and locks the grant for the whole burst.
- It sequences the clear, accumulate and result phases, and holds the sum until the consumer acknowledges it.
- Sits between the requester front-ends and the result consumer.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, data and accumulator width
- LENW, 8, burst-length field width (max burst 2^LENW-1 words)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  NREQ  per-requester burst request; level, held until GNT bit seen
- LEN  in  NREQ*LENW  per-requester burst length, slice i = requester i; sampled at grant
- D  in  NREQ*WIDTH  per-requester data, slice i = requester i
- DVALID  in  NREQ  per-requester data valid
- DREADY  out  NREQ  per-requester data ready; only the granted bit can be 1
- GNT  out  NREQ  one-hot grant, registered
- Q  out  WIDTH  accumulated sum
- QVALID  out  1  result valid
- QID  out  clog2(NREQ)  index of the requester that owns Q
- OVF  out  1  sticky carry-out seen during the current burst
- QACK  in  1  consumer acknowledges the result
- BUSY  out  1  state != IDLE

Behaviour:
- Reset (async, RST=1): state IDLE; GNT=0, DREADY=0, Q=0, QVALID=0, QID=0, OVF=0; round-robin pointer=0; beat counter=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - If any REQ is set, pick the first set bit at or after the pointer, wrapping.
  - At the next edge: GNT=onehot(winner), QID=winner, counter=LEN[winner], Q=0, OVF=0.
  - Next state is ACCUM, or DONE if LEN[winner]==0 (Q stays 0).
  - No REQ set: hold all state.
- ACCUM:
  - DREADY[g]=GNT[g], combinational from registered GNT.
  - A beat is accepted on an edge with DVALID[g]&DREADY[g]. Then Q<=Q+D[g] mod 2^WIDTH, OVF|=carry-out, counter decrements.
  - DVALID from non-granted requesters is ignored.
  - Dropping REQ[g] mid-burst is ignored; the burst completes.
  - When the accepted beat makes counter==0, the next state is DONE and GNT clears on the same edge.
- DONE:
  - QVALID=1; Q, QID and OVF held stable.
  - On an edge with QACK=1: QVALID=0, pointer=(QID+1) mod NREQ, next state IDLE.
  - QACK outside DONE is ignored.
- Latency:
  - REQ to GNT: 1 cycle.
  - Final beat to QVALID: 1 cycle.
  - QACK to next GNT: 2 cycles minimum (one IDLE cycle is mandatory).
- Back-to-back beats: one per cycle; DVALID stalls are tolerated indefinitely.
- Simultaneous REQs: round-robin order guarantees no starvation. After requester i is served, requester i has lowest priority.
- Wrap-around: the sum wraps modulo 2^WIDTH, with OVF=1 as a flag only.
- RST asserted mid-burst or in DONE: immediate return to the reset values. The partial sum is discarded; requesters must re-request.

Decomposition:
- Package prep6_acc_pkg:
  - state enum (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2)
  - localparams derived from NREQ (IDW=clog2(NREQ))
  - default WIDTH/LENW constants
- Sub-module prep6_rr_pick: combinational rotate-priority picker. Inputs REQ and pointer; outputs winner index and any-valid.
- The top level holds the FSM, counter, accumulator and output registers.

Test Plan:
- Reset then single burst: REQ[0]=1, LEN0=3, D0 beats 0x0001, 0x0002, 0x0003 back-to-back -> GNT=0001 one cycle after REQ; QVALID one cycle after 3rd beat, Q=0x0006, QID=0, OVF=0. Q holds until QACK.
- Round-robin: REQ=1111 held, every LEN=1, D_i=i+1, QACK immediate -> grant order 0,1,2,3,0; Q values 1,2,3,4,1.
- Wrap/overflow: LEN=2, beats 0xFFFF and 0x0002 -> Q=0x0001, OVF=1. The next burst starts with OVF=0.
- Stall and isolation: granted requester 2 toggles DVALID 1,0,0,1 while requester 1 drives DVALID=1, D=0x1234 -> DREADY[1] stays 0. Only requester 2's two beats are summed.
- LEN=0 and delayed ack: REQ[3], LEN3=0 -> DONE the cycle after grant with Q=0, QID=3. QACK held low 5 cycles -> QVALID stays 1 and no new GNT is issued.
- Mid-burst reset: RST pulsed after 2 of 4 beats (Q=0x0010) -> all outputs 0 and BUSY=0 immediately. A re-request gets GNT and the fresh sum starts at 0.
